top_divu_x3y3: RTL and testbench
================================

// Module: top_divu_x3y3
// PURPOSE
//  Sequential unsigned restoring divider. It is the inverse counterpart of the
//  combinational multiplier tiles and uses the same 8-bit io_in/io_out tile
//  interface. Operands are sampled from io_in; the core computes x / y, one
//  quotient bit per cycle. Quotient, remainder, divide-by-zero and a ready flag
//  are driven on io_out. It is a standalone tile with no handshake partner.
// PARAMETERS
//  X_WIDTH  3  dividend width; also quotient width and iteration count
//  Y_WIDTH  3  divisor width; also remainder width
// PORTS
//  Clock and reset are one clock, synchronous active-high reset, carried in io_in:
//  io_in[0]    clk  input   1        rising-edge clock
//  io_in[1]    rst  input   1        synchronous, active-high reset
//  io_in[4:2]  x    input   X_WIDTH  dividend
//  io_in[7:5]  y    input   Y_WIDTH  divisor
//  io_out[2:0] q    output  X_WIDTH  quotient, registered
//  io_out[5:3] r    output  Y_WIDTH  remainder, registered
//  io_out[6]   dz   output  1        divide-by-zero (y==0) for the displayed result
//  io_out[7]   rdy  output  1        q/r/dz are valid for the operands now latched
// BEHAVIOUR
//  - Reset: all io_out bits are 0. State is IDLE. Latched operands xr, yr, the
//    accumulator and the counter are cleared. Reset applies on any cycle,
//    including mid-ITER: the divide in progress is abandoned and no result appears.
//  - FSM states and transitions:
//    - IDLE -> LOAD: unconditional, on the first cycle after reset releases.
//    - LOAD: xr<=x, yr<=y, acc<=0, cnt<=0, rdy<=0. Then -> ITER.
//    - ITER: {acc,xr} <<= 1. If acc_shift >= yr: acc <= acc_shift - yr and the
//      new quotient LSB is 1. Otherwise acc is unchanged and the LSB is 0.
//      cnt += 1. When cnt == X_WIDTH-1, go -> DONE.
//    - DONE: q<=quotient, r<=acc[Y_WIDTH-1:0], dz<=(yr==0), rdy<=1.
//      Every cycle, compare io_in x,y against the operands captured at LOAD.
//      If they differ: -> LOAD and rdy<=0. Otherwise stay in DONE.
//  - Latency: a mismatch is seen in DONE at cycle T. LOAD runs at T+1, ITER at
//    T+2..T+1+X_WIDTH, and DONE with rdy=1 at T+2+X_WIDTH (5 cycles for the
//    defaults).
//  - q, r and dz hold the previous result while rdy=0. They change only on
//    entry to DONE.
//  - Operand changes during LOAD or ITER are ignored for the divide in
//    progress. The new operands are picked up by the DONE compare.
//  - Divide by zero: no special path. Restoring steps naturally give
//    q = all-ones and r = x. dz=1, with the same latency.
//  - Width rules:
//    - acc is Y_WIDTH+1 bits, so the trial subtract cannot overflow.
//    - The remainder is always < yr when yr != 0.
//    - The loop counter is sized clog2(X_WIDTH) and does not wrap within one
//      divide.
//  - io_in[1:0] are excluded from the operand compare.
// STRUCTURE
//  - Shared header config.vh holds: X_WIDTH and Y_WIDTH defaults, the io_out
//    bit-IDs (O_Q_BITID=0, O_R_BITID=3, O_DZ_BITID=6, O_READY_BITID=7), and the
//    FSM state localparams IDLE, LOAD, ITER, DONE.
//  - Sub-module divu_step: combinational single restoring step.
//    Inputs: acc, next dividend bit, divisor. Outputs: new acc, quotient bit.
//  - The top holds the FSM, operand latches, counter and output registers.
// TESTING
//  1. Reset, then x=7, y=2 held. Expect rdy=0 until 5 cycles after reset
//     release, then q=3, r=1, dz=0, rdy=1, stable while inputs hold.
//  2. In DONE, change to x=6, y=3. Expect rdy=0 on the next cycle and the old
//     q=3/r=1 held. Five cycles after the change: q=2, r=0, rdy=1.
//  3. x=5, y=0. Expect q=7, r=5, dz=1, rdy=1 after 5 cycles. Then x=5, y=1:
//     expect q=5, r=0, dz=0.
//  4. Edge values: x=0, y=7 -> q=0, r=0. x=7, y=7 -> q=1, r=0. x=7, y=1 -> q=7, r=0.
//  5. Start x=7, y=3. Change to x=4, y=2 during ITER. Expect the first result
//     q=2, r=1 with rdy=1. rdy drops the next cycle. Then q=2, r=0 after 5 more
//     cycles.
//  6. Assert rst for 1 cycle mid-ITER. Expect io_out=0 on the next cycle and a
//     fresh divide with rdy=1 five cycles after release. Never a partial result.

Source files
------------

// File: rtl/top_divu_x3y3_pkg.sv
// Shared widths, io bit positions, FSM encodings and payload layouts for the divider tile.
package top_divu_x3y3_pkg;

    localparam int unsigned X_WIDTH   = 3;
    localparam int unsigned Y_WIDTH   = 3;
    localparam int unsigned ACC_WIDTH = Y_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = $clog2(X_WIDTH);
    localparam int unsigned IO_WIDTH  = 8;

    // Bit positions of the result fields on io_out
    localparam int unsigned O_Q_BITID     = 0;
    localparam int unsigned O_R_BITID     = 3;
    localparam int unsigned O_DZ_BITID    = 6;
    localparam int unsigned O_READY_BITID = 7;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // io_in layout, MSB first
    typedef struct packed {
        logic [Y_WIDTH-1:0] y;
        logic [X_WIDTH-1:0] x;
        logic               rst;
        logic               clk;
    } in_t;

    // Result register contents
    typedef struct packed {
        logic               rdy;
        logic               dz;
        logic [Y_WIDTH-1:0] r;
        logic [X_WIDTH-1:0] q;
    } out_t;

endpackage

// File: rtl/top_divu_x3y3_if.sv
// 8-bit tile io bundle: io_in carries clock, reset and operands; io_out carries the result.
interface top_divu_x3y3_if;
    import top_divu_x3y3_pkg::*;

    logic [IO_WIDTH-1:0] io_in;
    logic [IO_WIDTH-1:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/top_divu_x3y3_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divu_step
    import top_divu_x3y3_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 bit_in,
    input  logic [Y_WIDTH-1:0]   div_in,
    output logic [ACC_WIDTH-1:0] acc_out_c,
    output logic                 q_bit_c
);

    logic [ACC_WIDTH:0] acc_shift;
    logic [ACC_WIDTH:0] div_ext;
    logic [ACC_WIDTH:0] diff;

    // Trial subtract is one bit wider than the accumulator so it can never wrap
    assign acc_shift = {acc_in, bit_in};
    assign div_ext   = (ACC_WIDTH+1)'(div_in);
    assign diff      = acc_shift - div_ext;
    assign q_bit_c   = (acc_shift >= div_ext);
    assign acc_out_c = q_bit_c ? ACC_WIDTH'(diff) : ACC_WIDTH'(acc_shift);

endmodule

// File: rtl/top_divu_x3y3.sv
// Sequential unsigned restoring divider tile: x / y, one quotient bit per cycle.
module top_divu_x3y3
    import top_divu_x3y3_pkg::*;
(
    top_divu_x3y3_if.slave bus
);

    in_t                  io_in_s;
    logic                 clk;
    logic                 rst;
    logic [X_WIDTH-1:0]   x;
    logic [Y_WIDTH-1:0]   y;

    logic [1:0]           state, state_nxt;
    logic [X_WIDTH-1:0]   x_cap, x_cap_nxt;
    logic [Y_WIDTH-1:0]   y_cap, y_cap_nxt;
    logic [X_WIDTH-1:0]   qx, qx_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    out_t                 out_q, out_nxt;

    logic [ACC_WIDTH-1:0] step_acc;
    logic                 step_q;
    logic [X_WIDTH-1:0]   quo_step;
    logic                 opnd_diff;

    // Unpack clock, reset and operands from the tile input bus
    assign io_in_s = bus.io_in;
    assign clk     = io_in_s.clk;
    assign rst     = io_in_s.rst;
    assign x       = io_in_s.x;
    assign y       = io_in_s.y;

    // Drive the registered result onto the tile output bus
    assign bus.io_out[O_Q_BITID +: X_WIDTH] = out_q.q;
    assign bus.io_out[O_R_BITID +: Y_WIDTH] = out_q.r;
    assign bus.io_out[O_DZ_BITID]           = out_q.dz;
    assign bus.io_out[O_READY_BITID]        = out_q.rdy;

    divu_step u_step (
        .acc_in    (acc),
        .bit_in    (qx[X_WIDTH-1]),
        .div_in    (y_cap),
        .acc_out_c (step_acc),
        .q_bit_c   (step_q)
    );

    // Dividend bits shift out of qx's MSB while quotient bits shift into its LSB
    assign quo_step  = {qx[X_WIDTH-2:0], step_q};
    assign opnd_diff = (x != x_cap) || (y != y_cap);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath/result values
    always_comb begin
        state_nxt = state;
        x_cap_nxt = x_cap;
        y_cap_nxt = y_cap;
        qx_nxt    = qx;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        out_nxt   = out_q;

        case (state)
            IDLE: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                x_cap_nxt   = x;
                y_cap_nxt   = y;
                qx_nxt      = x;
                acc_nxt     = '0;
                cnt_nxt     = '0;
                out_nxt.rdy = 1'b0;
                state_nxt   = ITER;
            end
            ITER: begin
                acc_nxt = step_acc;
                qx_nxt  = quo_step;
                cnt_nxt = cnt + CNT_WIDTH'(1);
                // Result registers load on the final step so rdy rises on DONE entry
                if (cnt == CNT_WIDTH'(X_WIDTH - 1)) begin
                    out_nxt.q   = quo_step;
                    out_nxt.r   = step_acc[Y_WIDTH-1:0];
                    out_nxt.dz  = (y_cap == '0);
                    out_nxt.rdy = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (opnd_diff) begin
                    out_nxt.rdy = 1'b0;
                    state_nxt   = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latches, working registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cap <= '0;
            y_cap <= '0;
            qx    <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            x_cap <= x_cap_nxt;
            y_cap <= y_cap_nxt;
            qx    <= qx_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
        end
    end

endmodule

// File: tb/tb_top_divu_x3y3.sv
// Directed bench for the divider tile; io_out sampled on the falling edge.
module tb_top_divu_x3y3;

    logic       clk;
    logic       rst;
    logic [2:0] x;
    logic [2:0] y;

    int vectors;
    int miscompares;

    top_divu_x3y3_if bus ();

    assign bus.io_in = {y, x, rst, clk};

    top_divu_x3y3 dut (
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected io_out word: {rdy, dz, r, q}
    function automatic logic [7:0] exp_out(input int q, input int r, input bit dz, input bit rdy);
        logic [2:0] q3;
        logic [2:0] r3;
        q3 = 3'(q);
        r3 = 3'(r);
        return {rdy, dz, r3, q3};
    endfunction

    task automatic check(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = bus.io_out;
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply new operands from DONE and check the 5-cycle turnaround plus one hold cycle
    task automatic run_div(input string tag, input logic [2:0] nx, input logic [2:0] ny,
                           input logic [7:0] old_o, input logic [7:0] new_o);
        logic [7:0] wait_o;
        wait_o    = old_o;
        wait_o[7] = 1'b0;
        x = nx;
        y = ny;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_wait"}, wait_o);
        end
        @(negedge clk);
        check({tag, "_result"}, new_o);
        @(negedge clk);
        check({tag, "_hold"}, new_o);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        x   = 3'd7;
        y   = 3'd2;

        // 1: reset, then 7/2 held
        @(negedge clk);
        @(negedge clk);
        check("reset_zero", 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_not_ready", 8'h00);
        end
        @(negedge clk);
        check("t1_7div2", exp_out(3, 1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_stable", exp_out(3, 1, 1'b0, 1'b1));
        end

        // 2: change to 6/3 in DONE
        run_div("t2_6div3", 3'd6, 3'd3, exp_out(3, 1, 1'b0, 1'b1), exp_out(2, 0, 1'b0, 1'b1));

        // 3: divide by zero, then 5/1
        run_div("t3_5div0", 3'd5, 3'd0, exp_out(2, 0, 1'b0, 1'b1), exp_out(7, 5, 1'b1, 1'b1));
        run_div("t3_5div1", 3'd5, 3'd1, exp_out(7, 5, 1'b1, 1'b1), exp_out(5, 0, 1'b0, 1'b1));

        // 4: edge values
        run_div("t4_0div7", 3'd0, 3'd7, exp_out(5, 0, 1'b0, 1'b1), exp_out(0, 0, 1'b0, 1'b1));
        run_div("t4_7div7", 3'd7, 3'd7, exp_out(0, 0, 1'b0, 1'b1), exp_out(1, 0, 1'b0, 1'b1));
        run_div("t4_7div1", 3'd7, 3'd1, exp_out(1, 0, 1'b0, 1'b1), exp_out(7, 0, 1'b0, 1'b1));

        // 5: start 7/3, switch to 4/2 once ITER is running
        x = 3'd7;
        y = 3'd3;
        @(negedge clk);
        check("t5_drop", exp_out(7, 0, 1'b0, 1'b0));
        @(negedge clk);
        check("t5_load", exp_out(7, 0, 1'b0, 1'b0));
        x = 3'd4;
        y = 3'd2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t5_iter", exp_out(7, 0, 1'b0, 1'b0));
        end
        @(negedge clk);
        check("t5_first_7div3", exp_out(2, 1, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_rerun_wait", exp_out(2, 1, 1'b0, 1'b0));
        end
        @(negedge clk);
        check("t5_second_4div2", exp_out(2, 0, 1'b0, 1'b1));

        // 6: reset pulse mid-ITER of 3/2
        x = 3'd3;
        y = 3'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_pre_reset", exp_out(2, 0, 1'b0, 1'b0));
        end
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_zero", 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_no_partial", 8'h00);
        end
        @(negedge clk);
        check("t6_3div2", exp_out(1, 1, 1'b0, 1'b1));
        @(negedge clk);
        check("t6_hold", exp_out(1, 1, 1'b0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
